// File: rtl/i2s_pkg.sv
// Shared I2S timing constants and sample type for the codec Pmod ADC and DAC paths.
package i2s_pkg;

    localparam int unsigned MCLK_TO_SCLK  = 6;
    localparam int unsigned SCLK_TO_LRCLK = 64;
    localparam int unsigned SAMPLE_WIDTH  = 24;

    localparam logic LEFT_CHANNEL  = 1'b0;
    localparam logic RIGHT_CHANNEL = 1'b1;

    typedef logic signed [23:0] sample_t;

endpackage

// File: rtl/dc_blocker.sv
// One-pole DC blocker with saturation; compiled only when I2S_ADC_DC_BLOCK_EN is defined.
`ifdef I2S_ADC_DC_BLOCK_EN
module dc_blocker
    import i2s_pkg::*;
#(
    parameter int unsigned DC_SHIFT = 10
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    valid_i,
    input  sample_t sample_i,
    output logic    valid_o,
    output sample_t sample_o
);

    localparam int unsigned AccW = 24 + DC_SHIFT;

    logic signed [AccW-1:0] acc_q, acc_d, acc_fb;
    logic signed [AccW:0]   diff;
    sample_t                y_sat, y_q;
    logic                   valid_q;

    always_comb begin
        acc_fb = acc_q >>> DC_SHIFT;
        diff   = {{(AccW - 23){sample_i[23]}}, sample_i} - {acc_fb[AccW-1], acc_fb};
        acc_d  = acc_q + diff[AccW-1:0];
        if ((diff[AccW:23] == '0) || (diff[AccW:23] == '1)) begin
            y_sat = diff[23:0];
        end else begin
            y_sat = diff[AccW] ? 24'sh800000 : 24'sh7FFFFF;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                acc_q <= acc_d;
                y_q   <= y_sat;
            end
        end
    end

    assign valid_o  = valid_q;
    assign sample_o = y_q;

endmodule
`endif

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock and word-select generator with falling-edge and capture strobes.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned MCLK_TO_SCLK  = i2s_pkg::MCLK_TO_SCLK,
    parameter int unsigned SCLK_TO_LRCLK = i2s_pkg::SCLK_TO_LRCLK
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    output logic                             sclk_o,
    output logic                             lrclk_o,
    output logic [$clog2(SCLK_TO_LRCLK)-1:0] bit_cnt_o,
    output logic                             fall_o,
    output logic                             capture_o
);

    localparam int unsigned CntW = $clog2(MCLK_TO_SCLK);
    localparam int unsigned BitW = $clog2(SCLK_TO_LRCLK);
    localparam logic [CntW-1:0] HalfCnt = CntW'(MCLK_TO_SCLK / 2);
    localparam logic [CntW-1:0] PreFall = CntW'(MCLK_TO_SCLK / 2 - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MCLK_TO_SCLK - 1);

    logic [CntW-1:0] sclk_cnt_q, sclk_cnt_d;
    logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
    logic            sclk_q, lrclk_q;
    logic            fall;

    always_comb begin
        fall       = (sclk_cnt_q == PreFall);
        sclk_cnt_d = (sclk_cnt_q == LastCnt) ? '0 : sclk_cnt_q + CntW'(1);
        bit_cnt_d  = fall ? bit_cnt_q + BitW'(1) : bit_cnt_q;
    end

    // Outputs are decoded from next-state so they stay aligned with the counters.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sclk_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
        end else begin
            sclk_cnt_q <= sclk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= (sclk_cnt_d < HalfCnt);
            lrclk_q    <= bit_cnt_d[BitW-1];
        end
    end

    assign sclk_o    = sclk_q;
    assign lrclk_o   = lrclk_q;
    assign bit_cnt_o = bit_cnt_q;
    assign fall_o    = fall;
    // Two synchroniser stages after the rise put the rising-edge pin value here.
    assign capture_o = fall;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S master receiver for the codec Pmod ADC; DC blocker enabled by I2S_ADC_DC_BLOCK_EN.
module i2s_adc_rx
    import i2s_pkg::*;
#(
    parameter int unsigned MCLK_TO_SCLK  = i2s_pkg::MCLK_TO_SCLK,
    parameter int unsigned SCLK_TO_LRCLK = i2s_pkg::SCLK_TO_LRCLK,
    parameter int unsigned SAMPLE_WIDTH  = i2s_pkg::SAMPLE_WIDTH,
    parameter int unsigned DC_SHIFT      = 10
) (
    input  logic    clk_i,
    input  logic    reset_i,
    output logic    i2s_adc_mclk_o,
    output logic    i2s_adc_sclk_o,
    output logic    i2s_adc_lrclk_o,
    input  logic    i2s_adc_sdout_i,
    output sample_t sample_l_o,
    output sample_t sample_r_o,
    output logic    sample_ready_o
);

    localparam int unsigned BitW = $clog2(SCLK_TO_LRCLK);
    localparam logic [BitW-2:0] LastSlot = (BitW - 1)'(SAMPLE_WIDTH);
    localparam logic [BitW-2:0] EndSlot  = '1;

    logic            fall, capture, in_word;
    logic [BitW-1:0] bit_cnt;
    logic [BitW-2:0] slot;
    logic [1:0]      sync_q;
    sample_t         shift_q, shift_nxt, left_hold_q, raw_l_q, raw_r_q;
    logic            left_valid_q, right_done_q, raw_ready_q;

    i2s_clk_gen #(
        .MCLK_TO_SCLK (MCLK_TO_SCLK),
        .SCLK_TO_LRCLK(SCLK_TO_LRCLK)
    ) u_clk_gen (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .sclk_o   (i2s_adc_sclk_o),
        .lrclk_o  (i2s_adc_lrclk_o),
        .bit_cnt_o(bit_cnt),
        .fall_o   (fall),
        .capture_o(capture)
    );

    assign i2s_adc_mclk_o = clk_i;

    always_comb begin
        slot      = bit_cnt[BitW-2:0];
        in_word   = (slot != '0) && (slot <= LastSlot);
        shift_nxt = {shift_q[22:0], sync_q[1]};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q       <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            left_valid_q <= 1'b0;
            right_done_q <= 1'b0;
            raw_l_q      <= '0;
            raw_r_q      <= '0;
            raw_ready_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], i2s_adc_sdout_i};
            right_done_q <= 1'b0;
            raw_ready_q  <= right_done_q;
            if (right_done_q) begin
                raw_l_q <= left_hold_q;
                raw_r_q <= shift_q;
            end
            if (capture && in_word) begin
                shift_q <= shift_nxt;
                if (slot == LastSlot) begin
                    if (bit_cnt[BitW-1] == LEFT_CHANNEL) begin
                        left_hold_q  <= shift_nxt;
                        left_valid_q <= 1'b1;
                    end else if (bit_cnt[BitW-1] == RIGHT_CHANNEL && left_valid_q) begin
                        right_done_q <= 1'b1;
                    end
                end
            end else if (fall && slot == EndSlot) begin
                // Start each word from a clean register.
                shift_q <= '0;
            end
        end
    end

`ifdef I2S_ADC_DC_BLOCK_EN
    logic ready_l, ready_r;

    dc_blocker #(
        .DC_SHIFT(DC_SHIFT)
    ) u_dc_l (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (raw_ready_q),
        .sample_i(raw_l_q),
        .valid_o (ready_l),
        .sample_o(sample_l_o)
    );

    dc_blocker #(
        .DC_SHIFT(DC_SHIFT)
    ) u_dc_r (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (raw_ready_q),
        .sample_i(raw_r_q),
        .valid_o (ready_r),
        .sample_o(sample_r_o)
    );

    assign sample_ready_o = ready_l & ready_r;
`else
    assign sample_l_o     = raw_l_q;
    assign sample_r_o     = raw_r_q;
    assign sample_ready_o = raw_ready_q;
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx with a behavioural I2S ADC driving SDOUT from the SCLK falls.
module tb_i2s_adc_rx;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sdout = 1'b0;
    logic               mclk, sclk, lrclk, ready;
    logic signed [23:0] l, r;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int dbl_cnt = 0;
    logic prev_rdy = 1'b0;

    logic [5:0]  mbit = '0;
    logic [23:0] def_l = '0, def_r = '0, cur_l = '0, cur_r = '0;
    bit          rand_mode = 1'b0;
    bit          jitter = 1'b0;
    logic [47:0] tx_q[$];
    logic [47:0] exp_q[$];
    logic [47:0] rx_q[$];
    int          rdy_cyc_q[$];

    i2s_adc_rx dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .i2s_adc_mclk_o (mclk),
        .i2s_adc_sclk_o (sclk),
        .i2s_adc_lrclk_o(lrclk),
        .i2s_adc_sdout_i(sdout),
        .sample_l_o     (l),
        .sample_r_o     (r),
        .sample_ready_o (ready)
    );

    always #5 clk = ~clk;

    task automatic pick_frame();
        if (rand_mode) begin
            cur_l = 24'($urandom);
            cur_r = 24'($urandom);
        end else if (tx_q.size() > 0) begin
            {cur_l, cur_r} = tx_q.pop_front();
        end else begin
            cur_l = def_l;
            cur_r = def_r;
        end
        exp_q.push_back({cur_l, cur_r});
    endtask

    // ADC model: MSB one SCLK after the LRCLK change, launched after each SCLK fall.
    initial begin
        forever begin
            @(negedge sclk);
            if (rst == 1'b0) begin
                automatic int          dly;
                automatic logic        d;
                automatic int          s;
                automatic logic [23:0] w;
                mbit = mbit + 6'd1;
                if (mbit == 6'd0) pick_frame();
                s = int'(mbit[4:0]);
                w = mbit[5] ? cur_r : cur_l;
                d = (s >= 1 && s <= 24) ? w[24-s] : 1'b0;
                dly = jitter ? 10 + int'($urandom_range(0, 10)) : 10;
                #(dly);
                sdout = d;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (ready === 1'b1) begin
            rx_q.push_back({l, r});
            rdy_cyc_q.push_back(cyc);
            if (prev_rdy) dbl_cnt++;
        end
        prev_rdy = ready;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic assert_reset();
        rst   = 1'b1;
        mbit  = '0;
        sdout = 1'b0;
        step();
    endtask

    task automatic release_reset();
        rx_q.delete();
        rdy_cyc_q.delete();
        exp_q.delete();
        dbl_cnt = 0;
        mbit    = '0;
        pick_frame();
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset();
        assert_reset();
        step();
        n_cmp++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        n_cmp++; if (lrclk !== 1'b0) begin n_fail++; $display("FAIL reset_lrclk: got %b want 0", lrclk); end
        n_cmp++; if (l !== 24'sd0) begin n_fail++; $display("FAIL reset_l: got %h want 0", l); end
        n_cmp++; if (r !== 24'sd0) begin n_fail++; $display("FAIL reset_r: got %h want 0", r); end
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (mclk !== clk) begin n_fail++; $display("FAIL mclk: got %b want %b", mclk, clk); end
    endtask

    task automatic test_clocks();
        int   tr = -1, tf = -1, tr2 = -1, bad = 0;
        int   tg[$];
        logic p, pl, ps;
        release_reset();
        repeat (20) step();
        p = sclk;
        for (int k = 0; k < 40 && tr2 < 0; k++) begin
            step();
            if (!p && sclk) begin
                if (tr < 0) tr = cyc;
                else if (tf >= 0) tr2 = cyc;
            end
            if (p && !sclk && tr >= 0 && tf < 0) tf = cyc;
            p = sclk;
        end
        n_cmp++; if (tf - tr !== 3) begin n_fail++; $display("FAIL sclk_high: got %0d want 3", tf - tr); end
        n_cmp++; if (tr2 - tf !== 3) begin n_fail++; $display("FAIL sclk_low: got %0d want 3", tr2 - tf); end
        pl = lrclk;
        ps = sclk;
        for (int k = 0; k < 1200 && tg.size() < 3; k++) begin
            step();
            if (lrclk !== pl) begin
                tg.push_back(cyc);
                if (!(ps === 1'b1 && sclk === 1'b0)) bad++;
            end
            pl = lrclk;
            ps = sclk;
        end
        n_cmp++; if (tg.size() !== 3) begin n_fail++; $display("FAIL lrclk_toggles: got %0d want 3", tg.size()); end
        if (tg.size() == 3) begin
            n_cmp++; if (tg[1] - tg[0] !== 192) begin n_fail++; $display("FAIL lrclk_half: got %0d want 192", tg[1] - tg[0]); end
            n_cmp++; if (tg[2] - tg[0] !== 384) begin n_fail++; $display("FAIL lrclk_period: got %0d want 384", tg[2] - tg[0]); end
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL lrclk_on_sclk_fall: got %0d misaligned want 0", bad); end
    endtask

`ifdef I2S_ADC_DC_BLOCK_EN
    task automatic test_dc_block();
        bit ok;
        def_l = 24'h100000;
        def_r = 24'h100000;
        assert_reset();
        release_reset();
        wait_rx(5, 2500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dc_ready_count: got %0d want 5", rx_q.size()); end
        if (ok) begin
            n_cmp++; if (rx_q[0] !== {24'h100000, 24'h100000}) begin n_fail++; $display("FAIL dc_first: got %h want 100000100000", rx_q[0]); end
            n_cmp++; if (rx_q[1] !== {24'h0FFC00, 24'h0FFC00}) begin n_fail++; $display("FAIL dc_second: got %h want 0ffc000ffc00", rx_q[1]); end
            for (int i = 2; i < 5; i++) begin
                n_cmp++;
                if (!($signed(rx_q[i][47:24]) < $signed(rx_q[i-1][47:24]) && $signed(rx_q[i][47:24]) > 0 &&
                      rx_q[i][47:24] === rx_q[i][23:0])) begin
                    n_fail++;
                    $display("FAIL dc_decay[%0d]: got %h prev %h want decreasing positive equal L/R", i, rx_q[i], rx_q[i-1]);
                end
            end
        end
    endtask
`else
    task automatic test_loopback();
        bit ok;
        def_l = 24'h123456;
        def_r = 24'hABCDEF;
        assert_reset();
        release_reset();
        wait_rx(3, 1400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL loop_ready_count: got %0d want 3", rx_q.size()); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rx_q[i] !== {24'h123456, 24'hABCDEF}) begin
                    n_fail++; $display("FAIL loop_pair[%0d]: got %h want 123456abcdef", i, rx_q[i]);
                end
            end
            n_cmp++; if (rdy_cyc_q[1] - rdy_cyc_q[0] !== 384) begin n_fail++; $display("FAIL loop_interval1: got %0d want 384", rdy_cyc_q[1] - rdy_cyc_q[0]); end
            n_cmp++; if (rdy_cyc_q[2] - rdy_cyc_q[1] !== 384) begin n_fail++; $display("FAIL loop_interval2: got %0d want 384", rdy_cyc_q[2] - rdy_cyc_q[1]); end
        end
        n_cmp++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL loop_pulse_width: got %0d long pulses want 0", dbl_cnt); end
    endtask

    task automatic test_extremes();
        bit ok;
        tx_q.delete();
        tx_q.push_back({24'h800000, 24'h7FFFFF});
        tx_q.push_back({24'h000000, 24'hFFFFFF});
        def_l = 24'h000000;
        def_r = 24'hFFFFFF;
        assert_reset();
        release_reset();
        wait_rx(2, 1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ext_ready_count: got %0d want 2", rx_q.size()); end
        if (ok) begin
            n_cmp++; if (rx_q[0] !== {24'h800000, 24'h7FFFFF}) begin n_fail++; $display("FAIL ext_pair0: got %h want 8000007fffff", rx_q[0]); end
            n_cmp++; if (rx_q[1] !== {24'h000000, 24'hFFFFFF}) begin n_fail++; $display("FAIL ext_pair1: got %h want 000000ffffff", rx_q[1]); end
        end
        repeat (50) step();
        n_cmp++; if ({l, r} !== {24'h000000, 24'hFFFFFF}) begin n_fail++; $display("FAIL ext_hold: got %h want 000000ffffff", {l, r}); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0, rel, d;
        def_l = 24'h111111;
        def_r = 24'h222222;
        assert_reset();
        release_reset();
        wait_rx(2, 1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_prefill: got %0d readies want 2", rx_q.size()); end
        while (mbit != 6'd40 && k < 400) begin
            step();
            k++;
        end
        n_cmp++; if (mbit !== 6'd40) begin n_fail++; $display("FAIL mid_reach_slot: got %0d want 40", mbit); end
        n_cmp++; if ({l, r} !== {24'h111111, 24'h222222}) begin n_fail++; $display("FAIL mid_before: got %h want 111111222222", {l, r}); end
        assert_reset();
        n_cmp++; if (rx_q.size() !== 2) begin n_fail++; $display("FAIL mid_no_pulse: got %0d readies want 2", rx_q.size()); end
        n_cmp++; if ({l, r} !== 48'h0) begin n_fail++; $display("FAIL mid_outputs: got %h want 0", {l, r}); end
        n_cmp++; if (lrclk !== 1'b0) begin n_fail++; $display("FAIL mid_lrclk: got %b want 0", lrclk); end
        n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", ready); end
        def_l = 24'h5A5A5A;
        def_r = 24'hA5A5A5;
        release_reset();
        rel = cyc;
        wait_rx(1, 500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_fresh_ready: got %0d want 1", rx_q.size()); end
        if (ok) begin
            d = rdy_cyc_q[0] - rel;
            n_cmp++; if (rx_q[0] !== {24'h5A5A5A, 24'hA5A5A5}) begin n_fail++; $display("FAIL mid_fresh_data: got %h want 5a5a5aa5a5a5", rx_q[0]); end
            n_cmp++; if (!(d >= 330 && d <= 360)) begin n_fail++; $display("FAIL mid_fresh_latency: got %0d want 330..360", d); end
        end
    endtask

    task automatic test_async();
        bit ok;
        int bad = 0;
        rand_mode = 1'b1;
        jitter    = 1'b1;
        assert_reset();
        release_reset();
        wait_rx(100, 100 * 384 + 800, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL async_ready_count: got %0d want 100", rx_q.size()); end
        if (ok) begin
            for (int i = 0; i < 100; i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_fail++;
                    bad++;
                    if (bad <= 5) $display("FAIL async_frame[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        rand_mode = 1'b0;
        jitter    = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_clocks();
`ifdef I2S_ADC_DC_BLOCK_EN
        test_dc_block();
`else
        test_loopback();
        test_extremes();
        test_reset_mid();
        test_async();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
